ped_crossing_ctrl: RTL and testbench

- Parametrised pedestrian-crossing controller. Next generation of the single-button car/pedestrian light.
- Adds configurable phase durations and N pedestrian request buttons with per-button "wait" lamps.
- Adds a mandatory all-red clearance phase, minimum car-green time, and a night flashing mode.
- Sits between the push-button debouncers and the lamp drivers. Lamp encoding: 001 RED, 010 ORANGE, 100 GREEN, 000 OFF.

---
 rtl/ped_crossing_ctrl.sv | 151 +++++++++++++++
 tb/tb_ped_crossing_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian-crossing controller: car/pedestrian lamp sequencing with N request
// buttons, minimum car green, all-red clearance and a night flashing mode.
module ped_crossing_ctrl #(
  parameter int unsigned N_REQ         = 2,
  parameter int unsigned STARTUP_CYC   = 3,
  parameter int unsigned MIN_GREEN_CYC = 4,
  parameter int unsigned AMBER_CYC     = 2,
  parameter int unsigned CLR_CYC       = 1,
  parameter int unsigned WALK_CYC      = 6,
  parameter int unsigned PCLR_CYC      = 2,
  parameter int unsigned FLASH_HALF    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             flash_mode,
  output logic [2:0]       light_car,
  output logic [2:0]       light_ped,
  output logic [N_REQ-1:0] req_pending,
  output logic [2:0]       phase
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAXD = max2(max2(max2(STARTUP_CYC, MIN_GREEN_CYC), max2(AMBER_CYC, CLR_CYC)),
                                      max2(max2(WALK_CYC, PCLR_CYC), FLASH_HALF));
  // Counter only ever holds values up to duration-1.
  localparam int unsigned CW = (MAXD > 1) ? $clog2(MAXD) : 1;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t LAST_IDLE  = cnt_t'(STARTUP_CYC - 1);
  localparam cnt_t LAST_GREEN = cnt_t'(MIN_GREEN_CYC - 1);
  localparam cnt_t LAST_AMBER = cnt_t'(AMBER_CYC - 1);
  localparam cnt_t LAST_CLR   = cnt_t'(CLR_CYC - 1);
  localparam cnt_t LAST_WALK  = cnt_t'(WALK_CYC - 1);
  localparam cnt_t LAST_PCLR  = cnt_t'(PCLR_CYC - 1);
  localparam cnt_t LAST_FLASH = cnt_t'(FLASH_HALF - 1);

  localparam logic [2:0] L_OFF    = 3'b000;
  localparam logic [2:0] L_RED    = 3'b001;
  localparam logic [2:0] L_ORANGE = 3'b010;
  localparam logic [2:0] L_GREEN  = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CAR_GO    = 3'd1,
    S_CAR_AMBER = 3'd2,
    S_ALL_RED   = 3'd3,
    S_PED_GO    = 3'd4,
    S_PED_CLEAR = 3'd5,
    S_FLASH     = 3'd6
  } state_t;

  state_t           state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  logic             tgt_ped_q, tgt_ped_d;
  logic             blink_q, blink_d;
  logic [2:0]       car_q, car_d;
  logic [2:0]       ped_q, ped_d;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic             latch_ok;

  // Next-state, counter, request latching and lamp decode of the state being entered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + cnt_t'(1);
    tgt_ped_d = tgt_ped_q;
    blink_d   = blink_q;
    pend_d    = pend_q;
    car_d     = L_ORANGE;
    ped_d     = L_ORANGE;

    latch_ok = (state_q == S_IDLE) || (state_q == S_CAR_GO) || (state_q == S_CAR_AMBER) ||
               (state_q == S_PED_CLEAR) || ((state_q == S_ALL_RED) && tgt_ped_q);
    if (latch_ok) pend_d = pend_q | req;

    case (state_q)
      S_IDLE: if (cnt_q == LAST_IDLE) state_d = S_CAR_GO;
      S_CAR_GO: begin
        // A press arriving this cycle counts toward leaving green.
        if (flash_mode) state_d = S_FLASH;
        else if (cnt_q >= LAST_GREEN) begin
          cnt_d = cnt_q;
          if (|pend_d) state_d = S_CAR_AMBER;
        end
      end
      S_CAR_AMBER: if (cnt_q == LAST_AMBER) begin
        state_d   = S_ALL_RED;
        tgt_ped_d = 1'b1;
      end
      S_ALL_RED: if (cnt_q == LAST_CLR) state_d = tgt_ped_q ? S_PED_GO : S_CAR_GO;
      S_PED_GO: if (cnt_q == LAST_WALK) state_d = S_PED_CLEAR;
      S_PED_CLEAR: if (cnt_q == LAST_PCLR) state_d = S_CAR_GO;
      S_FLASH: begin
        if (!flash_mode) begin
          state_d   = S_ALL_RED;
          tgt_ped_d = 1'b0;
        end else if (cnt_q == LAST_FLASH) begin
          cnt_d   = '0;
          blink_d = ~blink_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
    if (state_d == S_FLASH && state_q != S_FLASH) blink_d = 1'b1;
    if ((state_d == S_PED_GO && state_q != S_PED_GO) || state_d == S_FLASH) pend_d = '0;

    case (state_d)
      S_IDLE:      begin car_d = L_ORANGE; ped_d = L_ORANGE; end
      S_CAR_GO:    begin car_d = L_GREEN;  ped_d = L_RED;    end
      S_CAR_AMBER: begin car_d = L_ORANGE; ped_d = L_RED;    end
      S_ALL_RED:   begin car_d = L_RED;    ped_d = L_RED;    end
      S_PED_GO:    begin car_d = L_RED;    ped_d = L_GREEN;  end
      S_PED_CLEAR: begin car_d = L_RED;    ped_d = L_ORANGE; end
      S_FLASH:     begin car_d = blink_d ? L_ORANGE : L_OFF; ped_d = L_OFF; end
      default:     begin car_d = L_ORANGE; ped_d = L_ORANGE; end
    endcase
  end

  // State, counter and registered lamp/wait outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tgt_ped_q <= 1'b0;
      blink_q   <= 1'b1;
      car_q     <= L_ORANGE;
      ped_q     <= L_ORANGE;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tgt_ped_q <= tgt_ped_d;
      blink_q   <= blink_d;
      car_q     <= car_d;
      ped_q     <= ped_d;
      pend_q    <= pend_d;
    end
  end

  assign light_car   = car_q;
  assign light_ped   = ped_q;
  assign req_pending = pend_q;
  assign phase       = state_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Testbench for ped_crossing_ctrl: per-cycle vector table feeding a scoreboard queue.
module tb_ped_crossing_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req = 2'b00;
  logic       flash_mode = 1'b0;
  logic [2:0] light_car, light_ped, phase;
  logic [1:0] req_pending;

  always #5 clk = ~clk;

  ped_crossing_ctrl #(
    .N_REQ(2), .STARTUP_CYC(3), .MIN_GREEN_CYC(4), .AMBER_CYC(2),
    .CLR_CYC(1), .WALK_CYC(6), .PCLR_CYC(2), .FLASH_HALF(4)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .flash_mode(flash_mode),
    .light_car(light_car), .light_ped(light_ped),
    .req_pending(req_pending), .phase(phase)
  );

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic       fl;
    logic [2:0] car;
    logic [2:0] ped;
    logic [1:0] pend;
    logic [2:0] ph;
  } vec_t;

  typedef struct {
    int         idx;
    logic [2:0] car;
    logic [2:0] ped;
    logic [1:0] pend;
    logic [2:0] ph;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @vec %0d: got %b expected %b", nm, idx, act, exp);
    end
  endtask

  function automatic void add(input int n, input logic r, input logic [1:0] rq, input logic f,
                              input logic [2:0] car, input logic [2:0] ped,
                              input logic [1:0] pend, input logic [2:0] ph);
    vec_t v;
    v.rst = r; v.req = rq; v.fl = f; v.car = car; v.ped = ped; v.pend = pend; v.ph = ph;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endfunction

  // Compare the expected record for the current cycle away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("light_car",   e.idx, {5'd0, light_car},   {5'd0, e.car});
      chk("light_ped",   e.idx, {5'd0, light_ped},   {5'd0, e.ped});
      chk("req_pending", e.idx, {6'd0, req_pending}, {6'd0, e.pend});
      chk("phase",       e.idx, {5'd0, phase},       {5'd0, e.ph});
    end
  end

  task automatic run_table();
    exp_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      rst        = tbl[i].rst;
      req        = tbl[i].req;
      flash_mode = tbl[i].fl;
      e.idx = i; e.car = tbl[i].car; e.ped = tbl[i].ped; e.pend = tbl[i].pend; e.ph = tbl[i].ph;
      sb.push_back(e);
    end
    for (int k = 0; k < 10 && sb.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    chk("scoreboard_drain", tbl.size(), sb.size(), 0);
    tbl.delete();
  endtask

  initial begin
    // Start-up, 50-cycle idle green, then a full crossing (pulse at c53).
    add(3,  1, 2'b00, 0, 3'b010, 3'b010, 2'b00, 3'd0);
    add(50, 1, 2'b00, 0, 3'b100, 3'b001, 2'b00, 3'd1);
    add(1,  1, 2'b01, 0, 3'b100, 3'b001, 2'b00, 3'd1);
    add(2,  1, 2'b00, 0, 3'b010, 3'b001, 2'b01, 3'd2);
    add(1,  1, 2'b00, 0, 3'b001, 3'b001, 2'b01, 3'd3);
    add(2,  1, 2'b00, 0, 3'b001, 3'b100, 2'b00, 3'd4);
    add(1,  1, 2'b01, 0, 3'b001, 3'b100, 2'b00, 3'd4);
    add(3,  1, 2'b00, 0, 3'b001, 3'b100, 2'b00, 3'd4);
    // Press during pedestrian clearance: served after exactly the minimum green.
    add(1,  1, 2'b10, 0, 3'b001, 3'b010, 2'b00, 3'd5);
    add(1,  1, 2'b00, 0, 3'b001, 3'b010, 2'b10, 3'd5);
    add(1,  1, 2'b10, 0, 3'b100, 3'b001, 2'b10, 3'd1);
    add(3,  1, 2'b00, 0, 3'b100, 3'b001, 2'b10, 3'd1);
    add(2,  1, 2'b00, 0, 3'b010, 3'b001, 2'b10, 3'd2);
    add(1,  1, 2'b00, 0, 3'b001, 3'b001, 2'b10, 3'd3);
    add(6,  1, 2'b00, 0, 3'b001, 3'b100, 2'b00, 3'd4);
    add(2,  1, 2'b00, 0, 3'b001, 3'b010, 2'b00, 3'd5);
    // Flash with a pending request: request dropped, blink 4 on / 4 off, buttons ignored.
    add(1,  1, 2'b01, 0, 3'b100, 3'b001, 2'b00, 3'd1);
    add(1,  1, 2'b00, 1, 3'b100, 3'b001, 2'b01, 3'd1);
    add(4,  1, 2'b11, 1, 3'b010, 3'b000, 2'b00, 3'd6);
    add(4,  1, 2'b11, 1, 3'b000, 3'b000, 2'b00, 3'd6);
    add(4,  1, 2'b00, 1, 3'b010, 3'b000, 2'b00, 3'd6);
    add(1,  1, 2'b00, 0, 3'b000, 3'b000, 2'b00, 3'd6);
    // Clearance back to cars ignores presses; then a held press on the first green cycle.
    add(1,  1, 2'b01, 0, 3'b001, 3'b001, 2'b00, 3'd3);
    add(1,  1, 2'b10, 0, 3'b100, 3'b001, 2'b00, 3'd1);
    add(2,  1, 2'b10, 0, 3'b100, 3'b001, 2'b10, 3'd1);
    add(1,  1, 2'b00, 0, 3'b100, 3'b001, 2'b10, 3'd1);
    // flash_mode ignored during the pedestrian cycle.
    add(2,  1, 2'b00, 1, 3'b010, 3'b001, 2'b10, 3'd2);
    add(1,  1, 2'b00, 1, 3'b001, 3'b001, 2'b10, 3'd3);
    add(1,  1, 2'b00, 0, 3'b001, 3'b100, 2'b00, 3'd4);
    run_table();

    // Asynchronous reset in the middle of a walk phase, between edges.
    @(posedge clk);
    #2;
    chk("pre_reset_phase", -1, {5'd0, phase}, 8'd4);
    rst = 1'b0;
    #1;
    chk("rst_light_car",   -1, {5'd0, light_car},   8'b010);
    chk("rst_light_ped",   -1, {5'd0, light_ped},   8'b010);
    chk("rst_req_pending", -1, {6'd0, req_pending}, 8'd0);
    chk("rst_phase",       -1, {5'd0, phase},       8'd0);

    // Normal start-up after release; a press in IDLE is latched and served after min green.
    add(1, 1, 2'b00, 0, 3'b010, 3'b010, 2'b00, 3'd0);
    add(1, 1, 2'b01, 0, 3'b010, 3'b010, 2'b00, 3'd0);
    add(1, 1, 2'b00, 0, 3'b010, 3'b010, 2'b01, 3'd0);
    add(4, 1, 2'b00, 0, 3'b100, 3'b001, 2'b01, 3'd1);
    add(2, 1, 2'b00, 0, 3'b010, 3'b001, 2'b01, 3'd2);
    add(1, 1, 2'b00, 0, 3'b001, 3'b001, 2'b01, 3'd3);
    add(1, 1, 2'b00, 0, 3'b001, 3'b100, 2'b00, 3'd4);
    run_table();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
